// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: 2-entry result FIFO toward the register file plus the architectural SZCV flags.
// Optional macro EX_WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data, which mirror the youngest buffered entry.
module ex_wb_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [3:0]        alu_szcv,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wb_en,
    input  logic              set_flags,
    input  logic              sel_mem,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
`ifdef EX_WB_FWD_EN
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [3:0]        flags
);

    localparam logic [3:0] OP_CMP   = 4'b0101;
    localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

    logic [1:0]        r_count;
    logic              r_head;
    logic              r_tail;
    logic              r_we   [2];
    logic [ADDR_W-1:0] r_addr [2];
    logic [DATA_W-1:0] r_data [2];
    logic [3:0]        r_flags;

    logic w_valid;
    logic w_push;
    logic w_pop;
    logic w_c_upd;

    // Valid/ready: a transfer happens on an edge where valid & ready are both high;
    // in_ready depends only on registered occupancy, never on out_ready.
    assign w_valid  = (r_count != 2'd0);
    assign in_ready = (r_count < LP_DEPTH);
    assign w_push   = in_valid & in_ready;
    assign w_pop    = w_valid & out_ready;

    // Logic ops and moves leave carry alone; arithmetic, CMP and shifts produce it.
    assign w_c_upd = op inside {4'b0000, 4'b0001, 4'b0101, 4'b1000, 4'b1001, 4'b1010, 4'b1011};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_flags <= 4'b0000;
            for (int i = 0; i < 2; i++) begin
                r_we[i]   <= 1'b0;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            // Flags commit at accept, so a push discarded by flush still updates them.
            if (w_push && set_flags) begin
                r_flags <= {alu_szcv[3], alu_szcv[2], w_c_upd ? alu_szcv[1] : r_flags[1], alu_szcv[0]};
            end
            if (flush) begin
                r_count <= 2'd0;
                r_head  <= 1'b0;
                r_tail  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_we[r_tail]   <= wb_en & (op != OP_CMP);
                    r_addr[r_tail] <= rd;
                    r_data[r_tail] <= sel_mem ? mem_data : alu_res;
                    r_tail         <= ~r_tail;
                end
                if (w_pop) begin
                    r_head <= ~r_head;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign out_valid = w_valid;
    assign out_we    = w_valid & r_we[r_head];
    assign out_addr  = w_valid ? r_addr[r_head] : '0;
    assign out_data  = w_valid ? r_data[r_head] : '0;
    assign flags     = r_flags;

`ifdef EX_WB_FWD_EN
    logic w_young;
    logic w_fwd;
    assign w_young   = ~r_tail;
    assign w_fwd     = w_valid & r_we[w_young];
    assign fwd_valid = w_fwd;
    assign fwd_addr  = w_fwd ? r_addr[w_young] : '0;
    assign fwd_data  = w_fwd ? r_data[w_young] : '0;
`endif

endmodule
